pixel_fetch_unit: RTL and testbench

PIXEL_FETCH_UNIT -- requirements
Module: pixel_fetch_unit

---
 rtl/pixel_fetch_unit.sv | 155 +++++++++++++++
 tb/tb_pixel_fetch_unit.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pixel_fetch_unit.sv
// Pixel fetch: turns one address-calc result into a pixel colour,
// reading the font glyph bit from flash and/or the colour from RAM.
module pixel_fetch_unit #(
  parameter logic [7:0]  TIMEOUT_CYCLES    = 8'd255,
  parameter logic [15:0] TRANSPARENT_COLOR = 16'hF81F
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_is_sprite,
  input  logic        in_ram_en,
  input  logic        in_flash_en,
  input  logic [26:0] in_ram_offset,
  input  logic [29:0] in_flash_offset,
  output logic        ram_req,
  output logic [26:0] ram_addr,
  input  logic        ram_gnt,
  input  logic        ram_rvalid,
  input  logic [15:0] ram_rdata,
  output logic        flash_req,
  output logic [26:0] flash_addr,
  input  logic        flash_rvalid,
  input  logic [7:0]  flash_rdata,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_color,
  output logic        out_opaque,
  output logic        err_timeout
);

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_FLASH    = 3'd1;
  localparam logic [2:0] S_RAM_REQ  = 3'd2;
  localparam logic [2:0] S_RAM_WAIT = 3'd3;
  localparam logic [2:0] S_OUT      = 3'd4;

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        spr_q, spr_d;
  logic        ren_q, ren_d;
  logic [26:0] roff_q, roff_d;
  logic [29:0] foff_q, foff_d;
  logic [15:0] color_q, color_d;
  logic        opq_q, opq_d;
  logic        err_q, err_d;
  logic        flash_bit;
  logic        timed_out;
  logic        waiting;

  assign flash_bit = flash_rdata[3'd7 - foff_q[2:0]];
  assign timed_out = (cnt_q == TIMEOUT_CYCLES);
  assign waiting   = (state_q == S_FLASH) ||
                     (state_q == S_RAM_REQ) ||
                     (state_q == S_RAM_WAIT);

  always_comb begin
    state_d = state_q;
    spr_d   = spr_q;
    ren_d   = ren_q;
    roff_d  = roff_q;
    foff_d  = foff_q;
    color_d = color_q;
    opq_d   = opq_q;
    err_d   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          spr_d   = in_is_sprite;
          ren_d   = in_ram_en;
          roff_d  = in_ram_offset;
          foff_d  = in_flash_offset;
          color_d = 16'h0;
          opq_d   = 1'b0;
          if (in_flash_en && !in_is_sprite)
            state_d = S_FLASH;
          else if (in_ram_en)
            state_d = S_RAM_REQ;
          else
            state_d = S_OUT;
        end
      end
      S_FLASH: begin
        if (flash_rvalid) begin
          state_d = (flash_bit && ren_q) ? S_RAM_REQ : S_OUT;
        end else if (timed_out) begin
          state_d = S_OUT;
          err_d   = 1'b1;
        end
      end
      S_RAM_REQ: begin
        if (ram_gnt) begin
          state_d = S_RAM_WAIT;
        end else if (timed_out) begin
          state_d = S_OUT;
          err_d   = 1'b1;
        end
      end
      S_RAM_WAIT: begin
        if (ram_rvalid) begin
          state_d = S_OUT;
          color_d = ram_rdata;
          // text pixels are always drawn; sprites honour the colour key
          opq_d   = !spr_q || (ram_rdata != TRANSPARENT_COLOR);
        end else if (timed_out) begin
          state_d = S_OUT;
          err_d   = 1'b1;
        end
      end
      S_OUT: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q || !waiting)
      cnt_d = 8'd0;
    else
      cnt_d = cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 8'd0;
      spr_q   <= 1'b0;
      ren_q   <= 1'b0;
      roff_q  <= 27'd0;
      foff_q  <= 30'd0;
      color_q <= 16'h0;
      opq_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      spr_q   <= spr_d;
      ren_q   <= ren_d;
      roff_q  <= roff_d;
      foff_q  <= foff_d;
      color_q <= color_d;
      opq_q   <= opq_d;
      err_q   <= err_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign flash_req   = (state_q == S_FLASH);
  assign ram_req     = (state_q == S_RAM_REQ);
  assign out_valid   = (state_q == S_OUT);
  assign ram_addr    = roff_q;
  assign flash_addr  = foff_q[29:3];
  assign out_color   = color_q;
  assign out_opaque  = opq_q;
  assign err_timeout = err_q;

endmodule

// File: tb/tb_pixel_fetch_unit.sv
// Bench for pixel_fetch_unit: directed cases plus random transactions
// checked against a rule-level model of the expected pixel.
module tb_pixel_fetch_unit;

  localparam logic [15:0] TC = 16'hF81F;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_is_sprite, in_ram_en, in_flash_en;
  logic [26:0] in_ram_offset;
  logic [29:0] in_flash_offset;
  logic        ram_req, ram_gnt, ram_rvalid;
  logic [26:0] ram_addr;
  logic [15:0] ram_rdata;
  logic        flash_req, flash_rvalid;
  logic [26:0] flash_addr;
  logic [7:0]  flash_rdata;
  logic        out_valid, out_ready, out_opaque, err_timeout;
  logic [15:0] out_color;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pixel_fetch_unit #(
    .TIMEOUT_CYCLES(8'd255),
    .TRANSPARENT_COLOR(TC)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_is_sprite(in_is_sprite), .in_ram_en(in_ram_en),
    .in_flash_en(in_flash_en), .in_ram_offset(in_ram_offset),
    .in_flash_offset(in_flash_offset),
    .ram_req(ram_req), .ram_addr(ram_addr), .ram_gnt(ram_gnt),
    .ram_rvalid(ram_rvalid), .ram_rdata(ram_rdata),
    .flash_req(flash_req), .flash_addr(flash_addr),
    .flash_rvalid(flash_rvalid), .flash_rdata(flash_rdata),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_color(out_color), .out_opaque(out_opaque),
    .err_timeout(err_timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // One full transaction; the memory side answers after the given delays.
  task automatic run_txn(input bit spr, input bit ren, input bit fen,
                         input logic [26:0] roff, input logic [29:0] foff,
                         input logic [7:0] fdata, input int flat,
                         input int gdel, input int rlat, input int hold,
                         input logic [15:0] rdata, input bit noise);
    bit          use_flash, fbit, use_ram, eopq;
    int          sh;
    logic [15:0] ecol;
    use_flash = fen && !spr;
    sh        = 7 - int'(foff % 30'd8);
    fbit      = fdata[sh];
    use_ram   = ren && (!use_flash || fbit);
    ecol      = use_ram ? rdata : 16'h0;
    eopq      = use_ram && (!spr || rdata != TC);

    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_valid        = 1'b1;
    in_is_sprite    = spr;
    in_ram_en       = ren;
    in_flash_en     = fen;
    in_ram_offset   = roff;
    in_flash_offset = foff;
    tick();
    in_valid        = 1'b0;
    in_is_sprite    = ~spr;
    in_ram_en       = ~ren;
    in_flash_en     = ~fen;
    in_ram_offset   = 27'($urandom());
    in_flash_offset = 30'($urandom());
    chk("in_ready_busy", 32'(in_ready), 32'd0);

    if (use_flash) begin
      for (int i = 1; i < flat; i++) begin
        if (noise) begin
          ram_rvalid = 1'b1;
          ram_rdata  = 16'($urandom());
        end
        tick();
      end
      chk("flash_req", 32'(flash_req), 32'd1);
      chk("flash_addr", 32'(flash_addr), 32'(foff / 30'd8));
      ram_rvalid   = 1'b0;
      flash_rvalid = 1'b1;
      flash_rdata  = fdata;
      tick();
      flash_rvalid = 1'b0;
      flash_rdata  = 8'($urandom());
    end

    if (use_ram) begin
      chk("flash_req_off", 32'(flash_req), 32'd0);
      repeat (gdel) tick();
      chk("ram_req", 32'(ram_req), 32'd1);
      chk("ram_addr", 32'(ram_addr), 32'(roff));
      ram_gnt = 1'b1;
      tick();
      ram_gnt = 1'b0;
      chk("ram_req_drop", 32'(ram_req), 32'd0);
      repeat (rlat - 1) tick();
      ram_rvalid = 1'b1;
      ram_rdata  = rdata;
      tick();
      ram_rvalid = 1'b0;
      ram_rdata  = 16'($urandom());
    end

    chk("out_valid", 32'(out_valid), 32'd1);
    chk("out_color", 32'(out_color), 32'(ecol));
    chk("out_opaque", 32'(out_opaque), 32'(eopq));
    chk("err_none", 32'(err_timeout), 32'd0);
    chk("req_idle", 32'({ram_req, flash_req}), 32'd0);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_color", 32'(out_color), 32'(ecol));
      chk("hold_opaque", 32'(out_opaque), 32'(eopq));
      chk("hold_busy", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("done_valid", 32'(out_valid), 32'd0);
    chk("done_ready", 32'(in_ready), 32'd1);
  endtask

  bit          r_spr, r_ren, r_fen, r_noise;
  logic [26:0] r_roff;
  logic [29:0] r_foff;
  logic [7:0]  r_fdata;
  logic [15:0] r_rdata;
  int          cnt;

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_is_sprite = 1'b0; in_ram_en = 1'b0;
    in_flash_en = 1'b0; in_ram_offset = '0; in_flash_offset = '0;
    ram_gnt = 1'b0; ram_rvalid = 1'b0; ram_rdata = '0;
    flash_rvalid = 1'b0; flash_rdata = '0; out_ready = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_reqs", 32'({ram_req, flash_req}), 32'd0);
    chk("rst_out", 32'({out_valid, out_opaque, err_timeout}), 32'd0);
    chk("rst_color", 32'(out_color), 32'd0);
    chk("rst_ram_addr", 32'(ram_addr), 32'd0);
    chk("rst_flash_addr", 32'(flash_addr), 32'd0);

    // sprite green, sprite keyed, text glyph hit/miss, no-read
    run_txn(1, 1, 0, 27'h100, 30'h0, 8'h00, 1, 2, 3, 0, 16'h07E0, 0);
    run_txn(1, 1, 0, 27'h2A, 30'h0, 8'h00, 1, 0, 1, 1, TC, 0);
    run_txn(0, 1, 1, 27'h33, 30'h15, 8'b0000_0100, 2, 1, 2, 0,
            16'h1234, 1);
    run_txn(0, 1, 1, 27'h33, 30'h15, 8'h00, 3, 1, 2, 0, 16'h1234, 1);
    run_txn(0, 0, 0, 27'h7, 30'h9, 8'hFF, 1, 0, 1, 5, 16'hABCD, 0);
    run_txn(0, 1, 0, 27'h55, 30'h0, 8'h00, 1, 1, 1, 0, TC, 0);
    run_txn(0, 0, 1, 27'h55, 30'h0, 8'h80, 1, 1, 1, 0, 16'h1, 0);
    // grant on the very last allowed cycle still wins over the timeout
    run_txn(1, 1, 0, 27'h3FF, 30'h0, 8'h00, 1, 255, 1, 0, 16'h0F0F, 0);

    // grant never comes
    in_valid = 1'b1; in_is_sprite = 1'b1; in_ram_en = 1'b1;
    in_flash_en = 1'b0; in_ram_offset = 27'h44;
    tick();
    in_valid = 1'b0;
    cnt = 0;
    while (ram_req && cnt < 400) begin
      cnt++;
      tick();
    end
    chk("to_cycles", 32'(cnt), 32'd256);
    chk("to_err", 32'(err_timeout), 32'd1);
    chk("to_valid", 32'(out_valid), 32'd1);
    chk("to_opaque", 32'(out_opaque), 32'd0);
    chk("to_color", 32'(out_color), 32'd0);
    tick();
    chk("to_err_pulse", 32'(err_timeout), 32'd0);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("to_idle", 32'(in_ready), 32'd1);

    // reset in RAM_WAIT with a late response
    in_valid = 1'b1; in_is_sprite = 1'b1; in_ram_en = 1'b1;
    in_ram_offset = 27'h1AB;
    tick();
    in_valid = 1'b0;
    ram_gnt = 1'b1;
    tick();
    ram_gnt = 1'b0;
    rst = 1'b1;
    tick();
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_addr", 32'(ram_addr), 32'd0);
    rst = 1'b0;
    tick();
    ram_rvalid = 1'b1;
    ram_rdata  = 16'h07E0;
    tick();
    ram_rvalid = 1'b0;
    repeat (2) begin
      chk("post_rst_valid", 32'(out_valid), 32'd0);
      chk("post_rst_ready", 32'(in_ready), 32'd1);
      tick();
    end

    for (int t = 0; t < 40; t++) begin
      r_spr   = 1'($urandom_range(0, 1));
      r_ren   = ($urandom_range(0, 3) != 0);
      r_fen   = 1'($urandom_range(0, 1));
      r_noise = 1'($urandom_range(0, 1));
      r_roff  = 27'($urandom());
      r_foff  = 30'($urandom());
      r_fdata = 8'($urandom());
      r_rdata = ($urandom_range(0, 2) == 0) ? TC : 16'($urandom());
      run_txn(r_spr, r_ren, r_fen, r_roff, r_foff, r_fdata,
              $urandom_range(1, 4), $urandom_range(0, 3),
              $urandom_range(1, 4), $urandom_range(0, 3),
              r_rdata, r_noise);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
